// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the multi-cycle serial adder/subtractor:
// controller state encoding and step-counter sizing.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-step configuration still needs a one-bit counter.
    function automatic int cnt_width(input int nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle for serial_add_sub: operands and opcode in,
// status and result out.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder cell; chained to form the per-cycle slice of the
// serial adder.
module serial_add_sub_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic half_sum;

    assign half_sum = a_i ^ b_i;
    assign s_o      = half_sum ^ c_i;
    assign c_o      = (a_i & b_i) | (c_i & half_sum);

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: processes BPC bits per clock, LSB first,
// through a ripple chain of full adders with a registered carry between steps.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_sub_if.slave    bus
);

    localparam int NSTEP = WIDTH / BPC;
    localparam int CW    = cnt_width(NSTEP);
    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0 || $bits(bus.a) != WIDTH) begin : g_param_check
        $error("serial_add_sub: illegal WIDTH/BPC combination or interface width");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [BPC:0]     chain;
    logic [BPC-1:0]   step_sum;
    logic [WIDTH-1:0] res_d;

    assign chain[0] = carry_q;

    for (genvar gi = 0; gi < BPC; gi++) begin : g_fa
        serial_add_sub_full_adder u_fa (
            .a_i (a_q[gi]),
            .b_i (b_q[gi]),
            .c_i (chain[gi]),
            .s_o (step_sum[gi]),
            .c_o (chain[gi+1])
        );
    end

    // New sum bits enter at the MSB end; the oldest bits drift towards bit 0.
    assign res_d = WIDTH'({step_sum, res_q} >> BPC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    a_q     <= a_q >> BPC;
                    b_q     <= b_q >> BPC;
                    carry_q <= chain[BPC];
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        // Results are published only here, so they are never seen half-built.
                        sum_q   <= res_d;
                        cout_q  <= chain[BPC];
                        ovf_q   <= chain[BPC-1] ^ chain[BPC];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Drives three serial_add_sub instances (BPC = 1, 2, 8; WIDTH = 8) and checks
// latency, handshake and results against an integer-arithmetic model.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       start_v [3];
    logic       sub_v   [3];
    logic       cin_v   [3];
    logic [7:0] a_v     [3];
    logic [7:0] b_v     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [7:0] sum_v   [3];
    logic       cout_v  [3];
    logic       ovf_v   [3];

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int BP = (gi == 0) ? 1 : ((gi == 1) ? 2 : 8);

        serial_add_sub_if #(.WIDTH(8)) bus_if ();

        assign bus_if.start = start_v[gi];
        assign bus_if.sub   = sub_v[gi];
        assign bus_if.cin   = cin_v[gi];
        assign bus_if.a     = a_v[gi];
        assign bus_if.b     = b_v[gi];
        assign busy_v[gi]   = bus_if.busy;
        assign done_v[gi]   = bus_if.done;
        assign sum_v[gi]    = bus_if.sum;
        assign cout_v[gi]   = bus_if.cout;
        assign ovf_v[gi]    = bus_if.ovf;

        serial_add_sub #(.WIDTH(8), .BPC(BP)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if)
        );
    end

    function automatic int nstep_of(input int idx);
        return (idx == 0) ? 8 : ((idx == 1) ? 4 : 1);
    endfunction

    // Reference: plain unsigned and signed integer arithmetic on the operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic c, input logic s,
                                  output logic [7:0] sum, output logic co,
                                  output logic ov);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + int'(c);
            sr = sa + sb + int'(c);
            co = (ur > 255);
        end
        sum = 8'(ur);
        ov  = (sr > 127) || (sr < -128);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input int idx, input string tag, input logic [7:0] es,
                                 input logic eco, input logic eov);
        check({tag, ".sum"},  32'(sum_v[idx]),  32'(es));
        check({tag, ".cout"}, 32'(cout_v[idx]), 32'(eco));
        check({tag, ".ovf"},  32'(ovf_v[idx]),  32'(eov));
    endtask

    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input string tag);
        logic [7:0] es;
        logic       eco, eov;
        int         n, nb;
        model(a, b, c, s, es, eco, eov);
        a_v[idx]     = a;
        b_v[idx]     = b;
        cin_v[idx]   = c;
        sub_v[idx]   = s;
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        check({tag, ".busy_on"}, 32'(busy_v[idx]), 32'd1);
        n  = 0;
        nb = 1;
        while (!done_v[idx] && n < 40) begin
            tick();
            n++;
            if (busy_v[idx]) nb++;
        end
        check({tag, ".latency"}, 32'(n), 32'(nstep_of(idx)));
        check({tag, ".busy_cycles"}, 32'(nb), 32'(nstep_of(idx)));
        check({tag, ".busy_off"}, 32'(busy_v[idx]), 32'd0);
        check_results(idx, tag, es, eco, eov);
        tick();
        check({tag, ".done_pulse"}, 32'(done_v[idx]), 32'd0);
        check({tag, ".sum_held"}, 32'(sum_v[idx]), 32'(es));
    endtask

    initial begin
        logic [7:0] es;
        logic       eco, eov;
        int         n, first, second;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            sub_v[i]   = 1'b0;
            cin_v[i]   = 1'b0;
            a_v[i]     = 8'h00;
            b_v[i]     = 8'h00;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d.busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset%0d.done", i), 32'(done_v[i]), 32'd0);
            check($sformatf("reset%0d.out", i),
                  32'({sum_v[i], cout_v[i], ovf_v[i]}), 32'd0);
        end
        rst = 1'b0;
        tick();

        // Directed operations
        run_op(0, 8'h3C, 8'h0F, 1'b0, 1'b0, "add_bpc1");
        run_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, "add_bpc2_cin");
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf");
        run_op(0, 8'h05, 8'h07, 1'b1, 1'b1, "sub_borrow");
        run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, "add_bpc8_ovf");

        // Start held high: back-to-back operations restart from DONE
        model(8'h12, 8'h34, 1'b0, 1'b0, es, eco, eov);
        a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        start_v[0] = 1'b1;
        tick();
        first  = -1;
        second = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done_v[0]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check("hold.first_done", 32'(first), 32'd8);
        check("hold.period", 32'(second - first), 32'd9);
        start_v[0] = 1'b0;
        n = 0;
        while (!done_v[0] && n < 20) begin
            tick();
            n++;
        end
        check("hold.drain_done", 32'(done_v[0]), 32'd1);
        check_results(0, "hold", es, eco, eov);
        tick();

        // Start pulse during RUN must be ignored
        model(8'h5A, 8'h33, 1'b1, 1'b0, es, eco, eov);
        a_v[0] = 8'h5A; b_v[0] = 8'h33; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        a_v[0] = 8'hFF; b_v[0] = 8'hFF; sub_v[0] = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n = 3;
        while (!done_v[0] && n < 40) begin
            tick();
            n++;
        end
        check("midstart.latency", 32'(n), 32'd8);
        check_results(0, "midstart", es, eco, eov);
        tick();

        // Reset on the 4th RUN cycle abandons the operation
        a_v[0] = 8'h11; b_v[0] = 8'h22; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy", 32'(busy_v[0]), 32'd0);
        check("midrst.done", 32'(done_v[0]), 32'd0);
        check("midrst.out", 32'({sum_v[0], cout_v[0], ovf_v[0]}), 32'd0);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done_v[0]) n++;
        end
        check("midrst.no_done", 32'(n), 32'd0);
        run_op(0, 8'hC8, 8'h9C, 1'b1, 1'b0, "after_rst");

        // Randomized operations
        for (int i = 0; i < 20; i++)
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $sformatf("rnd_bpc1_%0d", i));
        for (int i = 0; i < 20; i++)
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $sformatf("rnd_bpc2_%0d", i));
        for (int i = 0; i < 1000; i++)
            run_op(2, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $sformatf("rnd_bpc8_%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor that adds WIDTH-bit operands BPC bits per clock, LSB first, using a chain of full_adder cells plus a carry register.
- Successor to the single-bit full_adder cell: adds width, throughput and subtract parameters, a start/done handshake, and signed-overflow detection.
- Sits in datapaths where area matters more than latency, such as accumulators and ALU slices.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- BPC, 1, bits processed per clock; must be at least 1 and divide WIDTH exactly. NSTEP = WIDTH/BPC.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE state.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while in RUN state.
- done  output  1  one-cycle pulse when results become valid.
- sum  output  WIDTH  result; held stable until the next accepted start.
- cout  output  1  carry out of the MSB. When sub=1, cout=1 means no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset: rst sampled high at a clock edge forces state=IDLE and busy=0, done=0, sum=0, cout=0, ovf=0, step counter=0. This applies in any state; an operation in progress is abandoned and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: load the A shift register with a. Load the B shift register with b, or with ~b when sub=1. Load the carry register with cin, or with 1 when sub=1. Clear the step counter. Go to RUN.
- RUN, each cycle:
  - Feed the low BPC bits of A and B plus the carry register through BPC chained full_adder cells.
  - Shift the BPC sum bits into the top of the result register, which fills from the MSB end and shifts right.
  - Shift A and B right by BPC.
  - Register the chain carry-out.
  - Increment the step counter.
- RUN exit: on the cycle the counter reaches NSTEP-1, the transition goes to DONE.
  - Capture cout = final chain carry-out.
  - Capture ovf = (carry into the MSB cell) XOR (carry out of the MSB cell). When BPC=1, the carry into the MSB cell is the carry register value before the last step.
- DONE: done=1 for exactly this one cycle.
  - start=1 here begins a new operation, next state RUN.
  - start=0 goes to IDLE.
- Latency: start accepted at edge E0 sets busy=1 after E0. The result is complete and visible after edge E_NSTEP, where done=1 and busy=0.
- start during RUN is ignored and does not disturb the operation.
- sum, cout and ovf update only on the RUN-to-DONE transition. They are never visible partially.
- Step counter width is $clog2(NSTEP) bits, minimum 1. The count never wraps in use, because it is cleared on every start.
- Subtract result is a + ~b + 1 modulo 2^WIDTH.

Decomposition:
- A shared package holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a function computing the counter width.
- The natural sub-module is the existing full_adder cell, instantiated BPC times in a generate loop as a ripple chain.
- No other sub-modules.

Test Plan (WIDTH=8 unless noted):
1. BPC=1: a=8'h3C, b=8'h0F, cin=0, sub=0; pulse start -> done exactly 8 cycles later with sum=8'h4B, cout=0, ovf=0; busy high for 8 cycles.
2. BPC=2: a=8'hFF, b=8'h01, cin=1, sub=0 -> done 4 cycles after start; sum=8'h01, cout=1, ovf=0.
3. Subtract with BPC=1: a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1. Then, after a fresh start with sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0.
4. Handshake corners:
   - Hold start high throughout -> the second operation begins in DONE, so done pulses every 9 cycles.
   - A start pulse mid-RUN changes neither the result nor the timing.
5. Reset mid-operation: assert rst on the 4th RUN cycle -> next cycle all outputs are 0 and state is IDLE, with no done pulse. A following start computes the correct fresh result.
6. BPC=WIDTH=8, random operands over 1000 operations -> done 1 cycle after each start; sum, cout and ovf match the reference model on every operation.
